// File: rtl/sha_block_feeder_if.sv
// 32-bit SHA word stream: feeder drives block/valid/first, the hash core answers with accept.
interface sha_block_feeder_if;
  logic [31:0] block;
  logic        valid;
  logic        first;
  logic        accept;

  modport master (output block, output valid, output first, input accept);
  modport slave  (input block, input valid, input first, output accept);
endinterface

// File: rtl/sha_block_feeder.sv
// Serialises a latched 512-bit block as 16 words, substituting a running nonce, repeated per count.
// Optional macro SHA_FEEDER_BYTESWAP_EN byte-reverses every word driven on the stream.
module sha_block_feeder #(
  parameter int unsigned WORDS     = 16,
  parameter int unsigned NONCE_IDX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [32*WORDS-1:0]   block_in,
  input  logic [31:0]           nonce_start,
  input  logic [31:0]           nonce_count,
  sha_block_feeder_if.master    bus,
  output logic [31:0]           nonce_cur,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [31:0]   left_q, left_nx;
  logic [31:0]   nonce_nx;
  logic [BW-1:0] blk_q;
  logic [BW-1:0] src;
  logic          load_en;
  logic          xfer;
  logic [31:0]   raw;
  logic [31:0]   block_q, block_nx;
  logic          valid_q, valid_nx;
  logic          first_q, first_nx;
  logic          busy_nx, done_nx;

  function automatic logic [31:0] drive_word(input logic [31:0] w);
`ifdef SHA_FEEDER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  assign xfer      = valid_q & bus.accept;
  assign bus.block = block_q;
  assign bus.valid = valid_q;
  assign bus.first = first_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and next datapath values
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    left_nx  = left_q;
    nonce_nx = nonce_cur;
    load_en  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          load_en  = 1'b1;
          idx_nx   = '0;
          nonce_nx = nonce_start;
          left_nx  = nonce_count;
          state_nx = (nonce_count != 32'd0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx == IW'(WORDS - 1)) begin
            if (left_q == 32'd1) begin
              state_nx = DONE;
            end else begin
              left_nx  = left_q - 32'd1;
              nonce_nx = nonce_cur + 32'd1;
              idx_nx   = '0;
            end
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode for the coming cycle, registered below
  always_comb begin
    src = load_en ? block_in : blk_q;
    raw = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx_nx == IW'(k)) raw = src[DW*(WORDS-k)-1 -: DW];
    end
    if (idx_nx == IW'(NONCE_IDX)) raw = nonce_nx;
    valid_nx = (state_nx == SEND);
    first_nx = valid_nx && (idx_nx == '0);
    block_nx = valid_nx ? drive_word(raw) : 32'd0;
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      left_q    <= '0;
      nonce_cur <= '0;
      blk_q     <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      idx       <= idx_nx;
      left_q    <= left_nx;
      nonce_cur <= nonce_nx;
      if (load_en) blk_q <= block_in;
      block_q   <= block_nx;
      valid_q   <= valid_nx;
      first_q   <= first_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_sha_block_feeder.sv
// Randomised bench for sha_block_feeder against a queue-based model of the expected word stream.
module tb_sha_block_feeder;

  localparam int unsigned WORDS     = 16;
  localparam int unsigned NONCE_IDX = 3;

  logic                clk;
  logic                rst;
  logic                load;
  logic [32*WORDS-1:0] block_in;
  logic [31:0]         nonce_start;
  logic [31:0]         nonce_count;
  logic [31:0]         nonce_cur;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;

  sha_block_feeder_if bus ();

  sha_block_feeder #(.WORDS(WORDS), .NONCE_IDX(NONCE_IDX)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .block_in    (block_in),
    .nonce_start (nonce_start),
    .nonce_count (nonce_count),
    .bus         (bus),
    .nonce_cur   (nonce_cur),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef SHA_FEEDER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [32*WORDS-1:0] rand_block();
    logic [32*WORDS-1:0] b;
    for (int k = 0; k < WORDS; k++) b[32*(WORDS-k)-1 -: 32] = $urandom;
    return b;
  endfunction

  // mode: 0 = accept always, 1 = random accept, 2 = stall 5 cycles at word 7
  task automatic run_job(input logic [31:0] nstart, input logic [31:0] cnt,
                         input int mode, input bit busy_load);
    logic [31:0] wd [WORDS];
    logic [32*WORDS-1:0] blk;
    logic [31:0] exp_q[$];
    logic [31:0] exp_n[$];
    bit          exp_f[$];
    int          sent;
    int          stall;
    bit          a;
    bit          finished;

    for (int k = 0; k < WORDS; k++) begin
      wd[k] = $urandom;
      blk[32*(WORDS-k)-1 -: 32] = wd[k];
    end
    for (logic [31:0] b = 0; b < cnt; b++) begin
      for (int k = 0; k < WORDS; k++) begin
        exp_q.push_back(exp_word((k == NONCE_IDX) ? nstart + b : wd[k]));
        exp_f.push_back(k == 0);
        exp_n.push_back(nstart + b);
      end
    end

    @(negedge clk);
    load = 1'b1; block_in = blk; nonce_start = nstart; nonce_count = cnt;
    @(negedge clk);
    load = 1'b0; block_in = rand_block(); nonce_start = $urandom; nonce_count = $urandom;

    sent = 0; stall = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (exp_q.size() == 0) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_at_done", 32'(bus.valid), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("nonce_at_done", nonce_cur, (cnt == 0) ? nstart : nstart + cnt - 32'd1);
        load = busy_load;
        nonce_count = 32'd1;
        finished = 1'b1;
        break;
      end
      chk("valid", 32'(bus.valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("word", bus.block, exp_q[0]);
      chk("first", 32'(bus.first), 32'(exp_f[0]));
      chk("nonce_cur", nonce_cur, exp_n[0]);
      case (mode)
        0:       a = 1'b1;
        1:       a = ($urandom_range(0, 3) != 0);
        default: a = !((sent % WORDS == 7) && (stall < 5));
      endcase
      if (!a) stall++;
      bus.accept = a;
      load = busy_load && ($urandom_range(0, 3) == 0);
      if (load) begin
        block_in = rand_block(); nonce_start = $urandom; nonce_count = $urandom_range(1, 5);
      end
      if (a) begin
        void'(exp_q.pop_front());
        void'(exp_f.pop_front());
        void'(exp_n.pop_front());
        sent++;
      end
      @(negedge clk);
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    @(negedge clk);
    load = 1'b0;
    bus.accept = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(bus.valid), 32'd0);
  endtask

  task automatic reset_mid_block();
    logic [32*WORDS-1:0] blk;
    blk = rand_block();
    @(negedge clk);
    load = 1'b1; block_in = blk; nonce_start = 32'h1234_5678; nonce_count = 32'd2;
    bus.accept = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("pre_reset_word5", bus.block, exp_word(blk[32*(WORDS-5)-1 -: 32]));
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(bus.valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_block", bus.block, 32'd0);
    chk("async_first", 32'(bus.first), 32'd0);
    chk("async_nonce", nonce_cur, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_done", 32'(done), 32'd0);
      chk("post_reset_valid", 32'(bus.valid), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end
    bus.accept = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; block_in = '0; nonce_start = '0; nonce_count = '0;
    bus.accept = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_block", bus.block, 32'd0);
    chk("rst_first", 32'(bus.first), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nonce", nonce_cur, 32'd0);
    rst = 1'b1;

    run_job(32'h1234_5678, 32'd1, 0, 1'b0);
    run_job(32'h0000_0010, 32'd3, 0, 1'b0);
    run_job(32'hFFFF_FFFF, 32'd2, 1, 1'b0);
    run_job($urandom, 32'd2, 2, 1'b0);
    run_job($urandom, 32'd0, 0, 1'b0);
    run_job($urandom, 32'd3, 1, 1'b1);
    for (int j = 0; j < 4; j++) run_job($urandom, 32'($urandom_range(0, 3)), 1, 1'b1);
    reset_mid_block();
    run_job(32'h1234_5678, 32'd1, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
